// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock enable, horizontal/vertical
// counters, sync pulses, visible-area qualifier and line/frame start pulses.
// Every output is registered on the same edge as the counters, so sync,
// blanking and pulses all line up exactly with pix_x/pix_y.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       rgbactive,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds are one bit wider than the counters so that a sync pulse
    // ending exactly at a 1024 total cannot wrap to zero.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_LVL = (SYNC_POL != 0);

    // Reject geometries the 10-bit coordinate ports cannot represent.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcount_q, hcount_d;
    logic [9:0]       vcount_q, vcount_d;
    logic             pix_ce_q, pix_ce_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             tick;
    logic             h_wrap;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    // Next-state: divider, counters and output decodes of the new position.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and infers a latch.
    always_comb begin
        tick     = (div_q == DIV_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        pix_ce_d = tick;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        active_d = active_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        h_wrap   = (hcount_q == H_LAST);
        h_ext    = '0;
        v_ext    = '0;
        if (tick) begin
            hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
            if (h_wrap) begin
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end
            line_d   = h_wrap;
            frame_d  = h_wrap && (vcount_q == V_LAST);
            h_ext    = {1'b0, hcount_d};
            v_ext    = {1'b0, vcount_d};
            hsync_d  = (h_ext >= H_SYNC_BEG && h_ext < H_SYNC_END) ? SYNC_LVL : ~SYNC_LVL;
            vsync_d  = (v_ext >= V_SYNC_BEG && v_ext < V_SYNC_END) ? SYNC_LVL : ~SYNC_LVL;
            active_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        end
    end

    // State register; reset parks the raster on the last position of a frame
    // so the first pix_ce after release starts a complete frame at (0,0).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            pix_ce_q <= 1'b0;
            hsync_q  <= ~SYNC_LVL;
            vsync_q  <= ~SYNC_LVL;
            active_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            pix_ce_q <= pix_ce_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgbactive   = active_q;
    assign pix_x       = hcount_q;
    assign pix_y       = vcount_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule
